// File: rtl/param_reg_file.sv
// param_reg_file: parametrised 2R/1W register file with registered read ports,
// write-to-read bypass, optional hardwired zero entry and a sequenced clear engine.
module param_reg_file #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 5,
    parameter bit                    ZERO_REG    = 1'b1,
    parameter bit                    BYPASS      = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  Clk,
    input  logic                  nRst,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [ADDR_WIDTH-1:0] WriteAddr,
    input  logic                  WriteEn,
    input  logic [ADDR_WIDTH-1:0] ReadA,
    input  logic                  ReadAEn,
    input  logic [ADDR_WIDTH-1:0] ReadB,
    input  logic                  ReadBEn,
    input  logic                  ClearReq,
    output logic [DATA_WIDTH-1:0] data_oA,
    output logic [DATA_WIDTH-1:0] data_oB,
    output logic                  Busy,
    output logic                  ClearDone
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, CLEARING, DONE} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  wr_user;
    logic [DATA_WIDTH-1:0] rd_a, rd_b;

    assign Busy      = state == CLEARING;
    assign ClearDone = state == DONE;
    assign wr_user   = WriteEn && !Busy;

    // Clear writes are never forwarded, so a read racing the clear sees pre-clear data.
    assign rd_a = (ZERO_REG && ReadA == '0) ? '0 :
                  (BYPASS && wr_user && WriteAddr == ReadA) ? data_i : mem[ReadA];
    assign rd_b = (ZERO_REG && ReadB == '0) ? '0 :
                  (BYPASS && wr_user && WriteAddr == ReadB) ? data_i : mem[ReadB];

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     state_next = ClearReq ? CLEARING : IDLE;
            CLEARING: state_next = (cnt == '1) ? DONE : CLEARING;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= Busy ? cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (Busy) begin
            if (!(ZERO_REG && cnt == '0)) mem[cnt] <= CLEAR_VALUE;
        end else if (WriteEn && !(ZERO_REG && WriteAddr == '0)) begin
            mem[WriteAddr] <= data_i;
        end
    end

    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            data_oA <= '0;
            data_oB <= '0;
        end else begin
            if (ReadAEn) data_oA <= rd_a;
            if (ReadBEn) data_oB <= rd_b;
        end
    end
endmodule

// File: tb/tb_param_reg_file.sv
// tb_param_reg_file: directed checks of param_reg_file with default, no-bypass
// and narrow/shallow (no zero register, all-ones clear) configurations.
module tb_param_reg_file;
    logic Clk = 1'b0;
    logic nRst = 1'b1;
    always #5 Clk = ~Clk;

    logic [31:0] wd, a0, b0, a1, b1;
    logic [4:0]  wa, ra, rb;
    logic        we, ae, be, creq, busy0, done0, busy1, done1;
    logic [15:0] wd2, a2, b2;
    logic [2:0]  wa2, ra2, rb2;
    logic        we2, ae2, be2, creq2, busy2, done2;

    int checks = 0;
    int fails = 0;

    param_reg_file d0 (
        .Clk(Clk), .nRst(nRst), .data_i(wd), .WriteAddr(wa), .WriteEn(we),
        .ReadA(ra), .ReadAEn(ae), .ReadB(rb), .ReadBEn(be), .ClearReq(creq),
        .data_oA(a0), .data_oB(b0), .Busy(busy0), .ClearDone(done0)
    );

    param_reg_file #(.BYPASS(1'b0)) d1 (
        .Clk(Clk), .nRst(nRst), .data_i(wd), .WriteAddr(wa), .WriteEn(we),
        .ReadA(ra), .ReadAEn(ae), .ReadB(rb), .ReadBEn(be), .ClearReq(creq),
        .data_oA(a1), .data_oB(b1), .Busy(busy1), .ClearDone(done1)
    );

    param_reg_file #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(1'b0), .CLEAR_VALUE(16'hFFFF)) d2 (
        .Clk(Clk), .nRst(nRst), .data_i(wd2), .WriteAddr(wa2), .WriteEn(we2),
        .ReadA(ra2), .ReadAEn(ae2), .ReadB(rb2), .ReadBEn(be2), .ClearReq(creq2),
        .data_oA(a2), .data_oB(b2), .Busy(busy2), .ClearDone(done2)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ae;
        logic [4:0]  ra;
        logic        be;
        logic [4:0]  rb;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] ea1;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [31:0] fillv(input int i);
        return (i == 0) ? 32'h0 : 32'h100 + 32'(i);
    endfunction

    function automatic vec_t mk(input logic w, input int wadr, input logic [31:0] wdat,
                                input logic ren_a, input int radr_a, input logic ren_b,
                                input int radr_b, input logic [31:0] ea, input logic [31:0] eb,
                                input logic [31:0] ea1);
        vec_t v;
        v.we = w; v.wa = 5'(wadr); v.wd = wdat;
        v.ae = ren_a; v.ra = 5'(radr_a); v.be = ren_b; v.rb = 5'(radr_b);
        v.ea = ea; v.eb = eb; v.ea1 = ea1;
        return v;
    endfunction

    initial begin
        int busy_n, done_n;
        {we, wa, wd, ae, ra, be, rb, creq} = '0;
        {we2, wa2, wd2, ae2, ra2, be2, rb2, creq2} = '0;
        #1 nRst = 1'b0;
        #3;
        chk("rst_a", a0, 0);
        chk("rst_b", b0, 0);
        chk("rst_busy", {31'b0, busy0}, 0);
        chk("rst_done", {31'b0, done0}, 0);
        chk("rst_a_small", {16'b0, a2}, 0);
        #8 nRst = 1'b1;

        for (int i = 0; i < 32; i++) begin
            we = 1'b1; wa = 5'(i); wd = 32'h100 + 32'(i);
            tick();
        end
        we = 1'b0;

        for (int i = 0; i < 32; i++)
            vecs.push_back(mk(0, 0, 0, 1, i, 1, 31 - i, fillv(i), fillv(31 - i), fillv(i)));
        vecs.push_back(mk(1, 5, 32'hDEADBEEF, 1, 5, 1, 5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h105));
        vecs.push_back(mk(1, 5, 32'h1, 0, 5, 0, 5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h105));
        vecs.push_back(mk(0, 5, 0, 1, 5, 1, 6, 32'h1, 32'h106, 32'h1));
        vecs.push_back(mk(1, 0, 32'hFFFF, 1, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 5, 32'h105, 1, 5, 0, 0, 32'h105, 0, 32'h1));

        foreach (vecs[n]) begin
            we = vecs[n].we; wa = vecs[n].wa; wd = vecs[n].wd;
            ae = vecs[n].ae; ra = vecs[n].ra; be = vecs[n].be; rb = vecs[n].rb;
            tick();
            chk($sformatf("vec%0d_a", n), a0, vecs[n].ea);
            chk($sformatf("vec%0d_b", n), b0, vecs[n].eb);
            chk($sformatf("vec%0d_a_nobyp", n), a1, vecs[n].ea1);
        end
        {we, ae, be} = '0;

        creq = 1'b1;
        tick();
        chk("clr_busy_start", {31'b0, busy0}, 1);
        busy_n = 1;
        done_n = 0;
        for (int k = 0; k < 32; k++) begin
            {we, ae, be, creq} = '0;
            if (k == 10) begin ae = 1'b1; ra = 5'd20; be = 1'b1; rb = 5'd3; end
            if (k == 20) begin we = 1'b1; wa = 5'd7; wd = 32'hAAAA; creq = 1'b1; end
            tick();
            if (busy0) busy_n++;
            if (done0 && k < 31) done_n++;
            if (k == 10) begin
                chk("mid_clr_old", a0, 32'h114);
                chk("mid_clr_new", b0, 0);
            end
        end
        chk("clr_busy_cycles", 32'(busy_n), 32);
        chk("clr_early_done", 32'(done_n), 0);
        chk("clr_done_pulse", {31'b0, done0}, 1);
        creq = 1'b1;
        tick();
        creq = 1'b0;
        chk("clr_done_end", {31'b0, done0}, 0);
        chk("clr_req_in_done", {31'b0, busy0}, 0);
        tick();
        chk("clr_idle", {31'b0, busy0}, 0);

        for (int i = 0; i < 32; i++) begin
            ae = 1'b1; ra = 5'(i); be = 1'b1; rb = 5'(i);
            tick();
            chk($sformatf("cleared_a%0d", i), a0, 0);
            chk($sformatf("cleared_b%0d", i), b1, 0);
        end
        {ae, be} = '0;

        we = 1'b1; wa = 5'd20; wd = 32'h55;
        tick();
        wa = 5'd25; wd = 32'h66;
        tick();
        we = 1'b0; ae = 1'b1; ra = 5'd20; be = 1'b1; rb = 5'd25;
        tick();
        chk("pre_rst_a", a0, 32'h55);
        chk("pre_rst_b", b0, 32'h66);
        {ae, be} = '0;
        creq = 1'b1;
        tick();
        creq = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        chk("pre_rst_busy", {31'b0, busy0}, 1);
        #3 nRst = 1'b0;
        #1;
        chk("async_rst_busy", {31'b0, busy0}, 0);
        chk("async_rst_a", a0, 0);
        chk("async_rst_b", b0, 0);
        #2 nRst = 1'b1;
        busy_n = 0;
        done_n = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (busy0) busy_n++;
            if (done0) done_n++;
        end
        chk("post_rst_busy", 32'(busy_n), 0);
        chk("post_rst_done", 32'(done_n), 0);
        ae = 1'b1; ra = 5'd20; be = 1'b1; rb = 5'd25;
        tick();
        chk("post_rst_a", a0, 0);
        chk("post_rst_b", b0, 0);
        {ae, be} = '0;

        we2 = 1'b1; wa2 = 3'd0; wd2 = 16'h1234;
        tick();
        wa2 = 3'd3; wd2 = 16'hABCD; ae2 = 1'b1; ra2 = 3'd0;
        tick();
        chk("small_zero_wr", {16'b0, a2}, 32'h1234);
        we2 = 1'b0; ra2 = 3'd3;
        tick();
        chk("small_rd3", {16'b0, a2}, 32'hABCD);
        ae2 = 1'b0;
        creq2 = 1'b1;
        tick();
        creq2 = 1'b0;
        busy_n = busy2 ? 1 : 0;
        done_n = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (busy2) busy_n++;
            if (done2) done_n++;
        end
        chk("small_busy_cycles", 32'(busy_n), 8);
        chk("small_done_pulses", 32'(done_n), 1);
        for (int i = 0; i < 8; i++) begin
            ae2 = 1'b1; ra2 = 3'(i); be2 = 1'b1; rb2 = 3'(7 - i);
            tick();
            chk($sformatf("small_clr_a%0d", i), {16'b0, a2}, 32'hFFFF);
            chk($sformatf("small_clr_b%0d", i), {16'b0, b2}, 32'hFFFF);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
